// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_seq_ctrl
// Purpose  : Run-control sequencer for the counter datapath. Owns the count
//            register and advances it through an external combinational
//            incrementer (inc_a -> inc_sum). Provides start/stop/clear
//            control, a programmable terminal count, one-shot or wrap modes,
//            and busy/done/tc_pulse status.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous, active-low reset
//            start      - begin / resume counting (level)
//            stop       - pause counting, RUN -> HOLD (level)
//            clear      - abort to IDLE and zero the count (level)
//            term       - terminal count value
//            mode_wrap  - 1: wrap to 0 at term, 0: one-shot, stop at term
//            inc_a      - incrementer operand (always equals count)
//            inc_sum    - incrementer result (inc_a + 1)
//            count      - current count (registered)
//            busy       - high in RUN or HOLD (registered)
//            done       - sticky one-shot completion flag
//            tc_pulse   - one-cycle pulse on each terminal-count event
//            prescale   - advance divider reload (COUNTER_PRESCALE_EN only)
// Options  : COUNTER_PRESCALE_EN - when defined, adds the prescale port and
//            an internal PS_WIDTH-bit divider; the count advances once every
//            (prescale + 1) RUN cycles.
// Revision : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl #(
    parameter int WIDTH    = 8,
    parameter int PS_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic [WIDTH-1:0]    term,
    input  logic                mode_wrap,
    output logic [WIDTH-1:0]    inc_a,
    input  logic [WIDTH-1:0]    inc_sum,
    output logic [WIDTH-1:0]    count,
    output logic                busy,
    output logic                done,
    output logic                tc_pulse
`ifdef COUNTER_PRESCALE_EN
    ,
    input  logic [PS_WIDTH-1:0] prescale
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   w_count_nxt;
    logic               r_busy;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_tc;
    logic               w_tc_nxt;
    logic               w_adv;
    logic               w_at_term;

    // Parameter sanity: a zero-width field cannot be built.
    if (WIDTH < 1 || PS_WIDTH < 1) begin : g_bad_params
        $error("counter_seq_ctrl: WIDTH and PS_WIDTH must be >= 1");
    end

    assign w_at_term = (r_count == term);

`ifdef COUNTER_PRESCALE_EN
    logic [PS_WIDTH-1:0] r_div;
    logic [PS_WIDTH-1:0] w_div_nxt;

    assign w_adv = (r_div == prescale);

    // Divider runs only while actively counting; it holds in HOLD so a
    // pause/resume does not lose the partial prescale period.
    always_comb begin
        w_div_nxt = r_div;
        if (clear) begin
            w_div_nxt = '0;
        end else if ((r_state == ST_IDLE || r_state == ST_DONE) && start) begin
            w_div_nxt = '0;
        end else if (r_state == ST_RUN && !stop) begin
            w_div_nxt = w_adv ? '0 : r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else begin
            r_div <= w_div_nxt;
        end
    end
`else
    assign w_adv = 1'b1;
`endif

    // Next-state / next-output logic. Priority: clear > stop > start.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done_nxt  = r_done;
        w_tc_nxt    = 1'b0;
        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_RUN;
                        w_count_nxt = '0;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        w_state_nxt = ST_RUN;
                        w_count_nxt = '0;
                        w_done_nxt  = 1'b0;
                    end
                end
                ST_RUN: begin
                    // stop wins over a simultaneous start: both -> HOLD.
                    if (stop) begin
                        w_state_nxt = ST_HOLD;
                    end else if (w_adv) begin
                        if (w_at_term) begin
                            w_tc_nxt = 1'b1;
                            if (mode_wrap) begin
                                w_count_nxt = '0;
                            end else begin
                                w_state_nxt = ST_DONE;
                                w_done_nxt  = 1'b1;
                            end
                        end else begin
                            w_count_nxt = inc_sum;
                        end
                    end
                end
                ST_HOLD: begin
                    // Resume from the held count; no reload.
                    if (start && !stop) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            // busy tracks the state being entered so it is aligned with it.
            r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_HOLD);
            r_done  <= w_done_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    assign inc_a    = r_count;
    assign count    = r_count;
    assign busy     = r_busy;
    assign done     = r_done;
    assign tc_pulse = r_tc;

endmodule : counter_seq_ctrl
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_seq_ctrl
// Purpose  : Self-checking bench for counter_seq_ctrl. Each scenario task
//            pushes the expected {count,busy,done,tc_pulse} tuple for a cycle
//            as it drives that cycle's stimulus, then pops and compares it
//            once the DUT has clocked. The incrementer is modelled here.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_seq_ctrl;

    localparam int W   = 8;
    localparam int PSW = 4;

    logic           clk       = 1'b0;
    logic           reset     = 1'b0;
    logic           start     = 1'b0;
    logic           stop      = 1'b0;
    logic           clear     = 1'b0;
    logic           mode_wrap = 1'b0;
    logic [W-1:0]   term      = '0;
    logic [W-1:0]   inc_a;
    logic [W-1:0]   inc_sum;
    logic [W-1:0]   count;
    logic           busy;
    logic           done;
    logic           tc_pulse;
`ifdef COUNTER_PRESCALE_EN
    logic [PSW-1:0] prescale = '0;
`endif

    int             errors = 0;
    int             checks = 0;
    logic [W+2:0]   sb[$];
    logic [W+2:0]   obs;

    counter_seq_ctrl #(
        .WIDTH    (W),
        .PS_WIDTH (PSW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .term      (term),
        .mode_wrap (mode_wrap),
        .inc_a     (inc_a),
        .inc_sum   (inc_sum),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .tc_pulse  (tc_pulse)
`ifdef COUNTER_PRESCALE_EN
        ,
        .prescale  (prescale)
`endif
    );

    always #5 clk = ~clk;

    // External incrementer
    assign inc_sum = inc_a + 8'd1;
    assign obs     = {count, busy, done, tc_pulse};

    function automatic logic [W+2:0] ex(input int c, input bit b, input bit d, input bit t);
        logic [31:0] cv;
        cv = c;
        return {cv[W-1:0], b, d, t};
    endfunction

    // Drive one cycle of control inputs, record what must appear after the
    // clock edge, and return 1 time unit after that edge.
    task automatic cyc(input bit s, input bit p, input bit c, input logic [W+2:0] want);
        start = s;
        stop  = p;
        clear = c;
        sb.push_back(want);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W+2:0] got;
        start = 1'b1;
        #1;
        got = obs; checks++;
        if (got !== ex(0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_t0: got count=%0d busy=%b done=%b tc=%b, expected all 0",
                     got[W+2:3], got[2], got[1], got[0]);
        end
        repeat (2) @(posedge clk);
        #1;
        got = obs; checks++;
        if (got !== ex(0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_held: got count=%0d busy=%b done=%b tc=%b, expected all 0",
                     got[W+2:3], got[2], got[1], got[0]);
        end
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // term=5 one-shot: 0..5, then tc+done with count held at 5, busy low.
    task automatic test_oneshot();
        logic [W+2:0] got, want;
        term = 8'd5; mode_wrap = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i == 0)      want = ex(0, 1, 0, 0);
            else if (i <= 5) want = ex(i, 1, 0, 0);
            else if (i == 6) want = ex(5, 0, 1, 1);
            else             want = ex(5, 0, 1, 0);
            cyc(i == 0, 0, 0, want);
            got = obs; want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL oneshot[%0d]: got count=%0d busy=%b done=%b tc=%b, expected count=%0d busy=%b done=%b tc=%b",
                         i, got[W+2:3], got[2], got[1], got[0], want[W+2:3], want[2], want[1], want[0]);
            end
        end
    endtask

    // term=3 wrap, started from DONE: done clears, 0,1,2,3,0(tc),1,...
    task automatic test_wrap();
        logic [W+2:0] got, want;
        term = 8'd3; mode_wrap = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) want = ex(0, 1, 0, 0);
            else        want = ex(i % 4, 1, 0, (i % 4) == 0);
            cyc(i == 0, 0, 0, want);
            got = obs; want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL wrap[%0d]: got count=%0d busy=%b done=%b tc=%b, expected count=%0d busy=%b done=%b tc=%b",
                         i, got[W+2:3], got[2], got[1], got[0], want[W+2:3], want[2], want[1], want[0]);
            end
        end
    endtask

    // Pause at 4 for three cycles, resume without reload; then start+stop
    // together in RUN must pause too.
    task automatic test_stop_resume();
        logic [W+2:0] got, want;
        bit [2:0]     st[16];
        int           ec[16];
        st = '{3'b001, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010,
               3'b010, 3'b100, 3'b000, 3'b000, 3'b110, 3'b000, 3'b100, 3'b000};
        ec = '{0, 0, 1, 2, 3, 4, 4, 4, 4, 4, 5, 6, 6, 6, 6, 7};
        term = 8'd20; mode_wrap = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc(st[i][2], st[i][1], st[i][0], ex(ec[i], i != 0, 0, 0));
            got = obs; want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL stop_resume[%0d]: got count=%0d busy=%b done=%b tc=%b, expected count=%0d busy=%b done=%b tc=%b",
                         i, got[W+2:3], got[2], got[1], got[0], want[W+2:3], want[2], want[1], want[0]);
            end
        end
    endtask

    // clear+start+stop at count 9 -> IDLE; clear in DONE drops done.
    task automatic test_clear_priority();
        logic [W+2:0] got, want;
        for (int i = 0; i < 17; i++) begin
            bit s, p, c;
            s = 0; p = 0; c = 0;
            if (i == 0) begin c = 1; want = ex(0, 0, 0, 0); term = 8'd20; mode_wrap = 1'b0; end
            else if (i == 1)  begin s = 1; want = ex(0, 1, 0, 0); end
            else if (i <= 10) want = ex(i - 1, 1, 0, 0);
            else if (i == 11) begin s = 1; p = 1; c = 1; want = ex(0, 0, 0, 0); end
            else if (i == 12) want = ex(0, 0, 0, 0);
            else if (i == 13) begin s = 1; term = 8'd1; want = ex(0, 1, 0, 0); end
            else if (i == 14) want = ex(1, 1, 0, 0);
            else if (i == 15) want = ex(1, 0, 1, 1);
            else begin c = 1; want = ex(0, 0, 0, 0); end
            cyc(s, p, c, want);
            got = obs; want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL clear_prio[%0d]: got count=%0d busy=%b done=%b tc=%b, expected count=%0d busy=%b done=%b tc=%b",
                         i, got[W+2:3], got[2], got[1], got[0], want[W+2:3], want[2], want[1], want[0]);
            end
        end
    endtask

    // term=0: one-shot finishes after one RUN cycle; wrap pulses every cycle.
    task automatic test_term_zero();
        logic [W+2:0] got, want;
        term = 8'd0;
        for (int i = 0; i < 8; i++) begin
            bit s;
            s = (i == 0) || (i == 3);
            mode_wrap = (i >= 3);
            if (i == 0 || i == 3) want = ex(0, 1, 0, 0);
            else if (i == 1)      want = ex(0, 0, 1, 1);
            else if (i == 2)      want = ex(0, 0, 1, 0);
            else                  want = ex(0, 1, 0, 1);
            cyc(s, 0, 0, want);
            got = obs; want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL term_zero[%0d]: got count=%0d busy=%b done=%b tc=%b, expected count=%0d busy=%b done=%b tc=%b",
                         i, got[W+2:3], got[2], got[1], got[0], want[W+2:3], want[2], want[1], want[0]);
            end
        end
        cyc(0, 0, 1, ex(0, 0, 0, 0));
        got = obs; want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL term_zero_clear: got count=%0d busy=%b done=%b tc=%b, expected all 0",
                     got[W+2:3], got[2], got[1], got[0]);
        end
    endtask

    // term=255 wrap across full range, then async reset mid-run.
    task automatic test_overflow_async_reset();
        logic [W+2:0] got, want;
        term = 8'hFF; mode_wrap = 1'b1;
        for (int i = 0; i < 259; i++) begin
            if (i == 0)        want = ex(0, 1, 0, 0);
            else if (i <= 255) want = ex(i, 1, 0, 0);
            else               want = ex(i - 256, 1, 0, i == 256);
            cyc(i == 0, 0, 0, want);
            got = obs; want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL overflow[%0d]: got count=%0d busy=%b done=%b tc=%b, expected count=%0d busy=%b done=%b tc=%b",
                         i, got[W+2:3], got[2], got[1], got[0], want[W+2:3], want[2], want[1], want[0]);
            end
        end
        // Mid-cycle, no clock edge between assertion and the check.
        #2 reset = 1'b0;
        #1;
        got = obs; checks++;
        if (got !== ex(0, 0, 0, 0)) begin
            errors++;
            $display("FAIL async_reset: got count=%0d busy=%b done=%b tc=%b, expected all 0",
                     got[W+2:3], got[2], got[1], got[0]);
        end
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 0, 0, ex(0, 0, 0, 0));
        got = obs; want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL post_reset_idle: got count=%0d busy=%b done=%b tc=%b, expected all 0",
                     got[W+2:3], got[2], got[1], got[0]);
        end
    endtask

    // Lowering term below count mid-run: no match until count wraps via 2^W.
    task automatic test_term_change();
        logic [W+2:0] got, want;
        term = 8'd10; mode_wrap = 1'b1;
        for (int i = 0; i < 262; i++) begin
            if (i == 7) term = 8'd3;
            if (i <= 259)      want = ex(i % 256, 1, 0, 0);
            else if (i == 260) want = ex(0, 1, 0, 1);
            else               want = ex(1, 1, 0, 0);
            cyc(i == 0, 0, 0, want);
            got = obs; want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL term_change[%0d]: got count=%0d busy=%b done=%b tc=%b, expected count=%0d busy=%b done=%b tc=%b",
                         i, got[W+2:3], got[2], got[1], got[0], want[W+2:3], want[2], want[1], want[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_wrap();
        test_stop_resume();
        test_clear_priority();
        test_term_zero();
        test_overflow_async_reset();
        test_term_change();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_counter_seq_ctrl
`default_nettype wire
